scl_clock_unit: RTL and testbench
=================================

# scl_clock_unit

Controller-side SCL clock generator with an integrated stall timer for the SDR controller. It produces the free-running SCL waveform in push-pull or open-drain timing, plus one-cycle rising- and falling-edge strobes that the SDR controller uses to launch and sample SDA. On request it freezes SCL low for a programmable number of system clocks and reports completion. It sits between the SDR controller FSM and the SCL pad driver.

## Interface
- No parameters. Timing is fixed for a 50 MHz system clock (20 ns).
- i_sdr_ctrl_clk  in  1  system clock; all logic on rising edge.
- i_sdr_ctrl_rst_n  in  1  reset; asynchronous assert, active-low.
- i_sdr_scl_gen_pp_od  in  1  1 = push-pull timing, 0 = open-drain timing.
- i_sdr_ctrl_scl_idle  in  1  1 = hold SCL high and reset the phase counter.
- i_timer_cas  in  1  1 = hold SCL high during the START-to-first-clock (tCAS) window; phase counter reset.
- i_scl_gen_stall  in  1  stall request level from the controller.
- i_stall_cycles  in  5  stall length in system clocks, 0..31.
- o_scl  out  1  generated SCL level.
- o_scl_pos_edge  out  1  one-cycle strobe in the cycle o_scl becomes 1 from 0.
- o_scl_neg_edge  out  1  one-cycle strobe in the cycle o_scl becomes 0 from 1.
- o_stall_done  out  1  stall complete; high until i_scl_gen_stall is low.
- o_scl_stall  out  1  high while SCL is being held by the stall timer.

## Operation
- Reset values:
  - o_scl=1.
  - o_scl_pos_edge=0, o_scl_neg_edge=0.
  - o_stall_done=0, o_scl_stall=0.
  - Phase counter=0; stall counter=0.
- Priority, highest first: reset, o_scl_stall, idle/cas, free-run.
- Free-run phases:
  - Push-pull: LOW 2 clocks, then HIGH 2 clocks; period 4 clocks (12.5 MHz).
  - Open-drain: LOW 10 clocks, then HIGH 2 clocks; period 12 clocks (~4.17 MHz).
  - The first phase after leaving idle/cas is LOW.
- A change of i_sdr_scl_gen_pp_od takes effect at the next phase boundary. The current phase completes with its old length.
- Idle or cas high:
  - o_scl is 1 and the phase counter is held at 0.
  - Forcing SCL high from low produces o_scl_pos_edge.
- Stall timer FSM, states IDLE, COUNT, DONE:
  - IDLE to COUNT: when i_scl_gen_stall=1 and i_stall_cycles≠0. Load count 1; o_scl_stall=1.
  - IDLE to DONE: when i_scl_gen_stall=1 and i_stall_cycles=0. o_stall_done=1; o_scl_stall stays 0.
  - COUNT: increment each clock. When count reaches i_stall_cycles, go to DONE: o_scl_stall=0, o_stall_done=1.
  - DONE to IDLE: when i_scl_gen_stall=0. o_stall_done=0.
  - i_scl_gen_stall dropping during COUNT aborts the stall: return to IDLE, o_scl_stall=0, no done.
  - i_stall_cycles is sampled every cycle; the team treats it as static during a stall.
- While o_scl_stall=1:
  - o_scl is 0 and the phase counter is frozen.
  - If SCL was high it falls immediately and o_scl_neg_edge pulses.
  - On release, the generator resumes the frozen phase at its frozen count.
  - If the frozen phase is HIGH, SCL rises in the first released cycle and o_scl_pos_edge pulses.
- Edge strobes are derived from the registered o_scl change, whatever caused it. They never assert in consecutive cycles for the same direction.

## Timing
- All outputs are registered.
- o_scl and the edge strobes update on the same clock edge.
- The stall request is seen at edge k; o_scl_stall=1 and o_scl=0 from edge k.
- With i_stall_cycles=N≥1, o_scl_stall is high for exactly N cycles. o_stall_done rises at edge k+N.
- Idle/cas assertion forces o_scl=1 at the next edge. On deassertion the first LOW phase starts at the next edge.
- Reset mid-stall or mid-period: all outputs return to reset values asynchronously. Operation restarts with the first LOW phase after release.

## Structure
- Top: scl_clock_unit, containing the phase counter, mode timing, and edge-strobe registers.
- Sub-module scl_staller: stall FSM and 5-bit counter. Its ports are clock, reset, flag, cycles, done, and scl_stall.
- Shared package holds:
  - Phase-length constants: PP_LOW=2, PP_HIGH=2, OD_LOW=10, OD_HIGH=2.
  - The stall-state enum.

## Test plan
- Reset 3 clocks, pp=1, idle=0, cas=0: SCL low 2 / high 2 repeating. One pos_edge per 4 clocks, one neg_edge per 4 clocks, never together.
- pp=0: SCL low 10 / high 2, period 12 clocks. Switching pp→od mid-period changes length only at the next phase boundary.
- i_stall_cycles=18, stall asserted after 102 clocks of run:
  - o_scl_stall high for 18 clocks with SCL low.
  - o_stall_done rises at clock 18, stays high until the flag drops, then clears.
  - SCL resumes its frozen phase.
- i_stall_cycles=0: o_stall_done next cycle, o_scl_stall never asserts, SCL unaffected.
- idle=1 then cas=1 mid-low-phase: SCL high next edge with a pos_edge pulse. After release, the first LOW begins one edge later.
- Reset asserted during COUNT: o_scl=1, stall outputs 0 immediately. After release, normal period with no spurious done.

Source files
------------

// File: rtl/scl_clock_unit_pkg.sv
// Shared definitions for the SCL clock unit.
//   - Phase lengths (in system clocks, 50 MHz) for push-pull and open-drain timing.
//   - Stall timer state encoding.
//   - phase_len(): length of a phase given the latched timing mode and the phase level.
package scl_clock_unit_pkg;

  localparam int unsigned PP_LOW  = 2;
  localparam int unsigned PP_HIGH = 2;
  localparam int unsigned OD_LOW  = 10;
  localparam int unsigned OD_HIGH = 2;

  localparam int unsigned PhaseCntW = 4;

  // Encoded so that bit 0 is "stalling" and bit 1 is "done".
  typedef enum logic [1:0] {
    StIdle  = 2'b00,
    StCount = 2'b01,
    StDone  = 2'b10
  } stall_state_e;

  function automatic logic [PhaseCntW-1:0] phase_len(input logic pp, input logic high);
    if (high) begin
      return pp ? PhaseCntW'(PP_HIGH) : PhaseCntW'(OD_HIGH);
    end
    return pp ? PhaseCntW'(PP_LOW) : PhaseCntW'(OD_LOW);
  endfunction

endpackage

// File: rtl/scl_clock_unit_staller.sv
// Stall timer: holds SCL low for a programmable number of system clocks.
//   clk_i       system clock
//   rst_ni      asynchronous active-low reset
//   flag_i      stall request level
//   cycles_i    stall length in clocks (0 = complete immediately, no hold)
//   done_o      stall complete; held until flag_i drops
//   scl_stall_o high while the stall is holding SCL
module scl_staller
  import scl_clock_unit_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       flag_i,
  input  logic [4:0] cycles_i,
  output logic       done_o,
  output logic       scl_stall_o
);

  stall_state_e state_q, state_d;
  logic [4:0]   cnt_q, cnt_d;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (flag_i) begin
          if (cycles_i != 5'd0) begin
            state_d = StCount;
            cnt_d   = 5'd1;
          end else begin
            state_d = StDone;
          end
        end
      end
      StCount: begin
        if (!flag_i) begin
          // Abort: no done indication.
          state_d = StIdle;
          cnt_d   = '0;
        end else if (cnt_q >= cycles_i) begin
          state_d = StDone;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 5'd1;
        end
      end
      StDone: begin
        if (!flag_i) begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
  end

  // State bits map directly onto the outputs, so both are flop outputs.
  always_comb begin
    scl_stall_o = state_q[0];
    done_o      = state_q[1];
  end

endmodule

// File: rtl/scl_clock_unit.sv
// SCL clock generator with integrated stall timer.
//   i_sdr_ctrl_clk       system clock (50 MHz)
//   i_sdr_ctrl_rst_n     asynchronous active-low reset
//   i_sdr_scl_gen_pp_od  1 = push-pull (2 low / 2 high), 0 = open-drain (10 low / 2 high)
//   i_sdr_ctrl_scl_idle  hold SCL high, restart phase sequence
//   i_timer_cas          hold SCL high during tCAS, restart phase sequence
//   i_scl_gen_stall      stall request level
//   i_stall_cycles       stall length in clocks
//   o_scl                SCL level
//   o_scl_pos_edge       strobe in the cycle o_scl rises
//   o_scl_neg_edge       strobe in the cycle o_scl falls
//   o_stall_done         stall complete
//   o_scl_stall          SCL held low by the stall timer
module scl_clock_unit
  import scl_clock_unit_pkg::*;
(
  input  logic       i_sdr_ctrl_clk,
  input  logic       i_sdr_ctrl_rst_n,
  input  logic       i_sdr_scl_gen_pp_od,
  input  logic       i_sdr_ctrl_scl_idle,
  input  logic       i_timer_cas,
  input  logic       i_scl_gen_stall,
  input  logic [4:0] i_stall_cycles,
  output logic       o_scl,
  output logic       o_scl_pos_edge,
  output logic       o_scl_neg_edge,
  output logic       o_stall_done,
  output logic       o_scl_stall
);

  logic                 run_q, run_d;    // a phase sequence is in progress
  logic                 ph_q, ph_d;      // current phase level, 1 = HIGH
  logic [PhaseCntW-1:0] cnt_q, cnt_d;    // clocks spent in current phase, minus one
  logic                 mode_q, mode_d;  // timing mode latched at phase start
  logic                 frz_q, frz_d;    // generator was frozen on the previous edge
  logic                 scl_q, scl_d;
  logic                 pos_q, pos_d;
  logic                 neg_q, neg_d;
  logic                 stall_start;
  logic                 freeze;

  scl_staller u_staller (
    .clk_i       (i_sdr_ctrl_clk),
    .rst_ni      (i_sdr_ctrl_rst_n),
    .flag_i      (i_scl_gen_stall),
    .cycles_i    (i_stall_cycles),
    .done_o      (o_stall_done),
    .scl_stall_o (o_scl_stall)
  );

  // The staller enters COUNT on this edge exactly when it is idle (neither output set) and a
  // non-zero request is present; SCL must drop on that same edge.
  assign stall_start = i_scl_gen_stall && (i_stall_cycles != 5'd0) &&
                       !o_scl_stall && !o_stall_done;
  assign freeze      = o_scl_stall || stall_start;

  always_comb begin
    run_d  = run_q;
    ph_d   = ph_q;
    cnt_d  = cnt_q;
    mode_d = mode_q;
    frz_d  = frz_q;
    scl_d  = scl_q;
    if (freeze) begin
      scl_d = 1'b0;
      frz_d = 1'b1;
    end else if (i_sdr_ctrl_scl_idle || i_timer_cas) begin
      scl_d = 1'b1;
      run_d = 1'b0;
      ph_d  = 1'b0;
      cnt_d = '0;
      frz_d = 1'b0;
    end else if (!run_q) begin
      // First phase of a sequence is always LOW.
      run_d  = 1'b1;
      ph_d   = 1'b0;
      cnt_d  = '0;
      mode_d = i_sdr_scl_gen_pp_od;
      scl_d  = 1'b0;
      frz_d  = 1'b0;
    end else if (frz_q) begin
      // Leaving a stall: re-present the frozen phase at its frozen count.
      scl_d = ph_q;
      frz_d = 1'b0;
    end else if (cnt_q == phase_len(mode_q, ph_q) - PhaseCntW'(1)) begin
      ph_d   = ~ph_q;
      cnt_d  = '0;
      mode_d = i_sdr_scl_gen_pp_od;
      scl_d  = ~ph_q;
    end else begin
      cnt_d = cnt_q + PhaseCntW'(1);
      scl_d = ph_q;
    end
  end

  always_comb begin
    pos_d = scl_d && !scl_q;
    neg_d = !scl_d && scl_q;
  end

  always_ff @(posedge i_sdr_ctrl_clk or negedge i_sdr_ctrl_rst_n) begin
    if (!i_sdr_ctrl_rst_n) begin
      run_q  <= 1'b0;
      ph_q   <= 1'b0;
      cnt_q  <= '0;
      mode_q <= 1'b0;
      frz_q  <= 1'b0;
      scl_q  <= 1'b1;
      pos_q  <= 1'b0;
      neg_q  <= 1'b0;
    end else begin
      run_q  <= run_d;
      ph_q   <= ph_d;
      cnt_q  <= cnt_d;
      mode_q <= mode_d;
      frz_q  <= frz_d;
      scl_q  <= scl_d;
      pos_q  <= pos_d;
      neg_q  <= neg_d;
    end
  end

  assign o_scl          = scl_q;
  assign o_scl_pos_edge = pos_q;
  assign o_scl_neg_edge = neg_q;

endmodule

// File: tb/tb_scl_clock_unit.sv
module tb_scl_clock_unit;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       pp = 1'b1;
  logic       idle = 1'b0;
  logic       cas = 1'b0;
  logic       stall_req = 1'b0;
  logic [4:0] stall_cycles = 5'd0;
  logic       scl, pos_edge, neg_edge, stall_done, scl_stall;

  int n_checks = 0;
  int n_errors = 0;

  scl_clock_unit dut (
    .i_sdr_ctrl_clk      (clk),
    .i_sdr_ctrl_rst_n    (rst_n),
    .i_sdr_scl_gen_pp_od (pp),
    .i_sdr_ctrl_scl_idle (idle),
    .i_timer_cas         (cas),
    .i_scl_gen_stall     (stall_req),
    .i_stall_cycles      (stall_cycles),
    .o_scl               (scl),
    .o_scl_pos_edge      (pos_edge),
    .o_scl_neg_edge      (neg_edge),
    .o_stall_done        (stall_done),
    .o_scl_stall         (scl_stall)
  );

  always #10 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: SCL levels come from a queue filled one whole phase at a time; the stall
  // is tracked as clocks remaining.
  bit m_scl, m_pos, m_neg, m_stall, m_done;
  bit m_run, m_resume, m_last, m_next_high;
  int m_left;
  bit lv_q[$];

  function automatic void model_reset();
    m_scl = 1'b1; m_pos = 1'b0; m_neg = 1'b0; m_stall = 1'b0; m_done = 1'b0;
    m_run = 1'b0; m_resume = 1'b0; m_last = 1'b0; m_next_high = 1'b0; m_left = 0;
    lv_q.delete();
  endfunction

  function automatic void model_edge();
    bit was_stall, start, nscl, nstall, ndone;
    int len;
    was_stall = m_stall;
    start  = stall_req && (stall_cycles != 0) && !m_stall && !m_done;
    nstall = m_stall;
    ndone  = m_done;
    if (m_stall) begin
      if (!stall_req) begin
        nstall = 1'b0;
        m_left = 0;
      end else if (m_left <= 1) begin
        nstall = 1'b0;
        ndone  = 1'b1;
      end else begin
        m_left--;
      end
    end else if (m_done) begin
      if (!stall_req) ndone = 1'b0;
    end else if (stall_req) begin
      if (stall_cycles == 0) ndone = 1'b1;
      else begin
        nstall = 1'b1;
        m_left = int'(stall_cycles);
      end
    end

    if (was_stall || start) begin
      nscl = 1'b0;
      m_resume = 1'b1;
    end else if (idle || cas) begin
      nscl = 1'b1;
      m_run = 1'b0;
      m_resume = 1'b0;
      lv_q.delete();
    end else if (m_resume && m_run) begin
      nscl = m_last;
      m_resume = 1'b0;
    end else begin
      if (!m_run) begin
        lv_q.delete();
        m_run = 1'b1;
        m_next_high = 1'b0;
      end
      if (lv_q.size() == 0) begin
        len = m_next_high ? 2 : (pp ? 2 : 10);
        for (int i = 0; i < len; i++) lv_q.push_back(m_next_high);
        m_next_high = !m_next_high;
      end
      m_last = lv_q.pop_front();
      nscl = m_last;
      m_resume = 1'b0;
    end
    m_pos   = nscl && !m_scl;
    m_neg   = !nscl && m_scl;
    m_scl   = nscl;
    m_stall = nstall;
    m_done  = ndone;
  endfunction

  task automatic compare_all();
    check_eq("scl", scl, m_scl);
    check_eq("pos_edge", pos_edge, m_pos);
    check_eq("neg_edge", neg_edge, m_neg);
    check_eq("stall_done", stall_done, m_done);
    check_eq("scl_stall", scl_stall, m_stall);
  endtask

  task automatic step();
    @(posedge clk);
    if (rst_n) model_edge();
    #1;
    compare_all();
  endtask

  initial begin
    model_reset();
    repeat (3) step();
    rst_n = 1'b1;

    // Push-pull, then open-drain free run.
    pp = 1'b1;
    repeat (40) step();
    pp = 1'b0;
    repeat (40) step();

    // Mode switches at arbitrary points in the period.
    for (int i = 0; i < 60; i++) begin
      step();
      if ($urandom_range(0, 6) == 0) pp = ~pp;
    end

    // 18-clock stall after a long run.
    pp = 1'($urandom_range(0, 1));
    repeat (102) step();
    stall_cycles = 5'd18;
    stall_req = 1'b1;
    repeat (25) step();
    stall_req = 1'b0;
    repeat (30) step();

    // Zero-length stall.
    stall_cycles = 5'd0;
    stall_req = 1'b1;
    repeat (3) step();
    stall_req = 1'b0;
    repeat (10) step();

    // Idle then cas, landing inside a low phase.
    pp = 1'b0;
    repeat (5) step();
    idle = 1'b1;
    repeat (3) step();
    idle = 1'b0;
    repeat (4) step();
    cas = 1'b1;
    repeat (3) step();
    cas = 1'b0;
    repeat (14) step();

    // Random soak.
    for (int i = 0; i < 3000; i++) begin
      step();
      if ($urandom_range(0, 19) == 0) stall_req = ~stall_req;
      if (!stall_req && $urandom_range(0, 3) == 0)
        stall_cycles = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 2))
                                                  : 5'($urandom_range(0, 31));
      if ($urandom_range(0, 9) == 0) pp = ~pp;
      if ($urandom_range(0, 59) == 0) idle = ~idle;
      if ($urandom_range(0, 59) == 0) cas = ~cas;
    end

    // Reset in the middle of a counting stall.
    stall_req = 1'b0;
    idle = 1'b0;
    cas = 1'b0;
    repeat (3) step();
    stall_cycles = 5'd20;
    stall_req = 1'b1;
    repeat (6) step();
    rst_n = 1'b0;
    #1;
    model_reset();
    compare_all();
    stall_req = 1'b0;
    repeat (2) step();
    rst_n = 1'b1;
    pp = 1'b1;
    repeat (30) step();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
